// File: rtl/mv_pwm_driver.sv
// -----------------------------------------------------------------------------
// mv_pwm_driver
//
// Converts the PID controller's signed fixed-point manipulation value (MV) into
// a complementary PWM pair with dead time. The MV is sampled once per PWM
// period, on the last count of the period, so that a new duty is valid from
// count 0. Samples flagged by the PID overflow vector are rejected. A run of
// FAULT_LIMIT consecutive rejected samples latches a fault that forces both
// gates low until the enable is dropped.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active low
//   en            run enable, level sensitive
//   mv[31:0]      signed MV with SHIFT fractional bits
//   of[2:0]       PID overflow flags; any set bit rejects the sample
//   pwm_h         high-side gate
//   pwm_l         low-side gate
//   duty[15:0]    active duty in clk cycles (0..PERIOD)
//   sat_hi        last accepted sample was clamped to PERIOD
//   sat_lo        last accepted sample was clamped to 0
//   fault         fault latched
//   period_start  one-cycle pulse on the cycle where the counter is 0 in RUN
// -----------------------------------------------------------------------------
module mv_pwm_driver #(
  parameter int PERIOD      = 100,
  parameter int SHIFT       = 8,
  parameter int DEADTIME    = 3,
  parameter int FAULT_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] mv,
  input  logic [2:0]  of,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic [15:0] duty,
  output logic        sat_hi,
  output logic        sat_lo,
  output logic        fault,
  output logic        period_start
);

  localparam int FCW = (FAULT_LIMIT < 2) ? 1 : $clog2(FAULT_LIMIT + 1);

  localparam logic [15:0]        LAST_CNT  = 16'(PERIOD - 1);
  localparam logic [15:0]        DUTY_MAX  = 16'(PERIOD);
  localparam logic [15:0]        DT_LOAD   = 16'(DEADTIME - 1);
  localparam logic [FCW-1:0]     FAULT_LIM = FCW'(FAULT_LIMIT);
  localparam logic signed [31:0] PERIOD_S  = PERIOD;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic [15:0]     r_duty;
  logic            r_sat_hi;
  logic            r_sat_lo;
  logic            r_raw_prev;
  logic [15:0]     r_dt;
  logic [FCW-1:0]  r_fault_cnt;
  logic            r_pwm_h;
  logic            r_pwm_l;
  logic            r_fault;
  logic            r_period_start;

  state_t          w_state_next;
  logic [15:0]     w_cnt_next;
  logic [15:0]     w_duty_next;
  logic            w_sat_hi_next;
  logic            w_sat_lo_next;
  logic            w_raw_prev_next;
  logic [15:0]     w_dt_next;
  logic [FCW-1:0]  w_fault_cnt_next;
  logic            w_pwm_h_next;
  logic            w_pwm_l_next;
  logic            w_fault_next;
  logic            w_period_start_next;

  logic signed [31:0] w_scaled;
  logic [15:0]        w_conv_duty;
  logic               w_conv_hi;
  logic               w_conv_lo;
  logic               w_raw;
  logic               w_sample;
  logic [FCW-1:0]     w_fcnt_inc;

  // Integer part of the MV; arithmetic shift keeps negative values negative.
  assign w_scaled   = $signed(mv) >>> SHIFT;
  assign w_raw      = (r_cnt < r_duty);
  assign w_fcnt_inc = r_fault_cnt + FCW'(1);

  // Clamp the scaled MV into 0..PERIOD and report which rail it hit.
  always_comb begin
    w_conv_duty = 16'd0;
    w_conv_hi   = 1'b0;
    w_conv_lo   = 1'b0;
    if (w_scaled < 0) begin
      w_conv_lo = 1'b1;
    end else if (w_scaled > PERIOD_S) begin
      w_conv_duty = DUTY_MAX;
      w_conv_hi   = 1'b1;
    end else begin
      w_conv_duty = w_scaled[15:0];
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_duty_next         = r_duty;
    w_sat_hi_next       = r_sat_hi;
    w_sat_lo_next       = r_sat_lo;
    w_raw_prev_next     = r_raw_prev;
    w_dt_next           = r_dt;
    w_fault_cnt_next    = r_fault_cnt;
    w_pwm_h_next        = 1'b0;
    w_pwm_l_next        = 1'b0;
    w_fault_next        = r_fault;
    w_period_start_next = 1'b0;
    w_sample            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_next = S_RUN;
          // Treat entry like a raw transition so the first output is
          // preceded by a full dead-time gap.
          w_dt_next    = DT_LOAD;
          w_sample     = 1'b1;
        end
      end

      S_RUN: begin
        if (!en) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next      = (r_cnt == LAST_CNT) ? 16'd0 : r_cnt + 16'd1;
          w_raw_prev_next = w_raw;
          if (w_raw != r_raw_prev) begin
            w_dt_next = DT_LOAD;
          end else if (r_dt != 16'd0) begin
            w_dt_next = r_dt - 16'd1;
          end else begin
            w_pwm_h_next = w_raw;
            w_pwm_l_next = ~w_raw;
          end
          w_sample = (r_cnt == LAST_CNT);
        end
      end

      S_FAULT: begin
        if (!en) begin
          w_state_next = S_IDLE;
        end else begin
          w_fault_next = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Sample handling is shared by IDLE entry and the RUN period wrap.
    if (w_sample) begin
      if (|of) begin
        w_fault_cnt_next = w_fcnt_inc;
        if (w_fcnt_inc == FAULT_LIM) begin
          w_state_next = S_FAULT;
          w_fault_next = 1'b1;
          w_pwm_h_next = 1'b0;
          w_pwm_l_next = 1'b0;
        end
      end else begin
        w_duty_next      = w_conv_duty;
        w_sat_hi_next    = w_conv_hi;
        w_sat_lo_next    = w_conv_lo;
        w_fault_cnt_next = '0;
      end
    end

    // Everything observable is zero while idle; the overflow run is also
    // forgotten so a re-enable starts with a clean count.
    if (w_state_next == S_IDLE) begin
      w_cnt_next       = 16'd0;
      w_duty_next      = 16'd0;
      w_sat_hi_next    = 1'b0;
      w_sat_lo_next    = 1'b0;
      w_raw_prev_next  = 1'b0;
      w_dt_next        = 16'd0;
      w_fault_cnt_next = '0;
      w_fault_next     = 1'b0;
    end

    w_period_start_next = (w_state_next == S_RUN) && (w_cnt_next == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 16'd0;
      r_duty         <= 16'd0;
      r_sat_hi       <= 1'b0;
      r_sat_lo       <= 1'b0;
      r_raw_prev     <= 1'b0;
      r_dt           <= 16'd0;
      r_fault_cnt    <= '0;
      r_pwm_h        <= 1'b0;
      r_pwm_l        <= 1'b0;
      r_fault        <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_duty         <= w_duty_next;
      r_sat_hi       <= w_sat_hi_next;
      r_sat_lo       <= w_sat_lo_next;
      r_raw_prev     <= w_raw_prev_next;
      r_dt           <= w_dt_next;
      r_fault_cnt    <= w_fault_cnt_next;
      r_pwm_h        <= w_pwm_h_next;
      r_pwm_l        <= w_pwm_l_next;
      r_fault        <= w_fault_next;
      r_period_start <= w_period_start_next;
    end
  end

  assign pwm_h        = r_pwm_h;
  assign pwm_l        = r_pwm_l;
  assign duty         = r_duty;
  assign sat_hi       = r_sat_hi;
  assign sat_lo       = r_sat_lo;
  assign fault        = r_fault;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_mv_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_mv_pwm_driver
//
// Scoreboard bench for mv_pwm_driver. A reference model evaluates the
// driver's rules on every rising edge and queues the expected outputs; a
// monitor on the falling edge pops and compares. The dead-time rule is
// modelled as "raw must have held the same value for DEADTIME+1 consecutive
// samples", with RUN entry counting as a sample of 0. A second monitor checks
// whole-period on-times against the closed-form duty-DEADTIME formula.
// -----------------------------------------------------------------------------
module tb_mv_pwm_driver;

  localparam int P  = 100;
  localparam int SH = 8;
  localparam int DT = 3;
  localparam int FL = 3;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] mv;
  logic [2:0]  of;
  logic        pwm_h;
  logic        pwm_l;
  logic [15:0] duty;
  logic        sat_hi;
  logic        sat_lo;
  logic        fault;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  mv_pwm_driver #(
    .PERIOD      (P),
    .SHIFT       (SH),
    .DEADTIME    (DT),
    .FAULT_LIMIT (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mv           (mv),
    .of           (of),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .duty         (duty),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo),
    .fault        (fault),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        h;
    logic        l;
    logic [15:0] duty;
    logic        shi;
    logic        slo;
    logic        flt;
    logic        ps;
  } obs_t;

  obs_t exp_q[$];

  int m_mode = 0;   // 0 idle, 1 run, 2 fault
  int m_cnt  = 0;
  int m_duty = 0;
  int m_fcnt = 0;
  bit m_hi   = 0;
  bit m_lo   = 0;
  bit m_flt  = 0;
  bit m_hist[$];

  function automatic void model_idle();
    m_mode = 0;
    m_cnt  = 0;
    m_duty = 0;
    m_hi   = 0;
    m_lo   = 0;
    m_fcnt = 0;
    m_flt  = 0;
    m_hist.delete();
  endfunction

  function automatic void model_sample();
    int s;
    if (of != 3'b000) begin
      m_fcnt = m_fcnt + 1;
      if (m_fcnt >= FL) begin
        m_mode = 2;
        m_flt  = 1;
      end
    end else begin
      s = $signed(mv) >>> SH;
      if (s < 0) begin
        m_duty = 0; m_lo = 1; m_hi = 0;
      end else if (s > P) begin
        m_duty = P; m_lo = 0; m_hi = 1;
      end else begin
        m_duty = s; m_lo = 0; m_hi = 0;
      end
      m_fcnt = 0;
    end
  endfunction

  always @(posedge clk) begin
    bit   ph;
    bit   pl;
    bit   raw;
    bit   stable;
    obs_t e;
    ph = 0;
    pl = 0;
    if (!rst) begin
      model_idle();
    end else if (m_mode == 0) begin
      if (en) begin
        m_mode = 1;
        m_cnt  = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        model_sample();
      end
    end else if (m_mode == 1) begin
      if (!en) begin
        model_idle();
      end else begin
        raw = (m_cnt < m_duty);
        m_hist.push_back(raw);
        if (m_hist.size() > DT + 1) void'(m_hist.pop_front());
        stable = (m_hist.size() == DT + 1);
        foreach (m_hist[k]) if (m_hist[k] != raw) stable = 0;
        ph = stable && raw;
        pl = stable && !raw;
        if (m_cnt == P - 1) begin
          m_cnt = 0;
          model_sample();
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (m_mode == 2) begin
          ph = 0;
          pl = 0;
        end
      end
    end else begin
      if (!en) model_idle();
    end
    e.h    = ph;
    e.l    = pl;
    e.duty = 16'(m_duty);
    e.shi  = m_hi;
    e.slo  = m_lo;
    e.flt  = m_flt;
    e.ps   = (m_mode == 1) && (m_cnt == 0);
    exp_q.push_back(e);
  end

  // ---------------------------------------------------------------------------
  // Cycle monitor: pop expected outputs and compare.
  // ---------------------------------------------------------------------------
  int cyc = 0;

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.h = pwm_h; a.l = pwm_l; a.duty = duty; a.shi = sat_hi;
      a.slo = sat_lo; a.flt = fault; a.ps = period_start;
      total = total + 1;
      if (a !== e) begin
        bad = bad + 1;
        $display("FAIL outputs cyc=%0d got h=%b l=%b duty=%0d shi=%b slo=%b flt=%b ps=%b want h=%b l=%b duty=%0d shi=%b slo=%b flt=%b ps=%b",
                 cyc, a.h, a.l, a.duty, a.shi, a.slo, a.flt, a.ps,
                 e.h, e.l, e.duty, e.shi, e.slo, e.flt, e.ps);
      end
      total = total + 1;
      if (pwm_h === 1'b1 && pwm_l === 1'b1) begin
        bad = bad + 1;
        $display("FAIL overlap cyc=%0d got h=1 l=1 want not both high", cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Period monitor: one line per period, plus on-time formula check when this
  // period and the previous one ran uninterrupted with the same duty.
  // ---------------------------------------------------------------------------
  bit in_win    = 0;
  bit win_clean = 0;
  bit prev_ok   = 0;
  int prev_duty = -1;
  int w_len = 0, w_h = 0, w_l = 0, w_duty = 0, n_per = 0;

  always @(negedge clk) begin
    int want_h;
    int want_l;
    bit cur_ok;
    if (period_start === 1'b1) begin
      cur_ok = in_win && win_clean && (w_len == P);
      if (cur_ok && prev_ok && prev_duty == w_duty && w_duty > 0 && w_duty < P) begin
        want_h = (w_duty - DT > 0) ? w_duty - DT : 0;
        want_l = (P - w_duty - DT > 0) ? P - w_duty - DT : 0;
        total = total + 2;
        if (w_h != want_h) begin
          bad = bad + 1;
          $display("FAIL h_ontime duty=%0d got %0d want %0d", w_duty, w_h, want_h);
        end
        if (w_l != want_l) begin
          bad = bad + 1;
          $display("FAIL l_ontime duty=%0d got %0d want %0d", w_duty, w_l, want_l);
        end
      end
      if (in_win)
        $display("period %0d: duty=%0d len=%0d h_on=%0d l_on=%0d", n_per, w_duty, w_len, w_h, w_l);
      n_per     = n_per + 1;
      prev_ok   = cur_ok;
      prev_duty = w_duty;
      in_win    = 1;
      win_clean = 1;
      w_len = 0; w_h = 0; w_l = 0;
      w_duty = int'(duty);
    end
    if (in_win) begin
      w_len = w_len + 1;
      if (pwm_h === 1'b1) w_h = w_h + 1;
      if (pwm_l === 1'b1) w_l = w_l + 1;
      if (m_mode != 1) win_clean = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (m_mode == 1 && m_cnt == target) return;
    end
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL wait_cnt got timeout want cnt=%0d", target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; mv = 32'd0; of = 3'b000;
    step(3);
    rst = 1'b1;
    step(3);

    // Nominal 50% duty.
    mv = 32'd12800;
    en = 1'b1;
    step(4 * P);

    // Clamp at both rails.
    mv = -32'sd256;
    step(3 * P);
    mv = 32'd51200;
    step(3 * P);

    // Mid-period MV change only takes effect at the wrap.
    mv = 32'd12800;
    step(2 * P);
    wait_cnt(20);
    mv = 32'd6400;
    step(3 * P);

    // Two rejected samples, recovery, then a run that latches the fault.
    wait_cnt(50);
    of = 3'b010;
    mv = 32'd20000;
    wait_cnt(50);
    wait_cnt(50);
    of = 3'b000;
    mv = 32'd12800;
    wait_cnt(50);
    wait_cnt(50);
    of = 3'b001;
    wait_cnt(50);
    wait_cnt(50);
    step(60);
    step(20);
    en = 1'b0;
    of = 3'b000;
    step(3);
    en = 1'b1;
    step(3 * P);

    // Reset in the middle of a high pulse.
    wait_cnt(40);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(3 * P);

    // Enable drop mid-period.
    wait_cnt(10);
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(3 * P);

    // Randomised segments.
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 9))
        0:       mv = 32'h7fff_ffff;
        1:       mv = 32'h8000_0000;
        default: mv = 32'($signed($urandom_range(0, 32000)) - 4000);
      endcase
      of = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      en = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      step($urandom_range(1, 150));
    end
    of = 3'b000;
    en = 1'b1;
    mv = 32'd12800;
    step(3 * P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
